dmem_responder: RTL and testbench

Data-memory responder for the core's load/store path: accepts one RV32I load/store request at a time from the execute stage over a valid/ready channel. It performs the access with byte-lane granularity and returns a registered response, with sign/zero extension and error signalling. Memory is zeroed by a hardware sweep after every reset. It sits beside the instruction memory as the target end of the executer's memory interface, replacing the in-stage memory array.

---
 rtl/dmem_responder_pkg.sv | 59 +++++
 rtl/dmem_ram.sv | 29 ++
 rtl/dmem_responder.sv | 108 ++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared load/store definitions: funct3 encodings, responder state enum,
// and the byte-lane helpers used by the data-memory responder.
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_ACCESS, ST_RESP} dmem_state_e;

  // Encoding/alignment error; the address range check lives in the responder.
  function automatic logic f3_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    f3_err = 1'b0;
      F3_BU:   f3_err = we;
      F3_H:    f3_err = off[0];
      F3_HU:   f3_err = we | off[0];
      F3_W:    f3_err = |off;
      default: f3_err = 1'b1;
    endcase
  endfunction

  function automatic logic [NUM_LANES-1:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data so every candidate lane carries it.
  function automatic logic [31:0] store_align(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   store_align = {4{wd[7:0]}};
      2'b01:   store_align = {2{wd[15:0]}};
      default: store_align = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    load_ext = {{24{b[7]}}, b};
      F3_BU:   load_ext = {24'b0, b};
      F3_H:    load_ext = {{16{h[15]}}, h};
      F3_HU:   load_ext = {16'b0, h};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 single-port RAM, per-byte-lane write enable, registered read.
// Contents are not reset; the responder sweeps them to zero.
module dmem_ram
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      CLK,
  input  logic                      rd_en,
  input  logic [NUM_LANES-1:0]      we,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [NUM_LANES-1:0][7:0] wdata,
  output logic [NUM_LANES-1:0][7:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge CLK) begin
      if (we[l]) mem[addr] <= wdata[l];
      if (rd_en) rd_q <= mem[addr];
    end

    assign rdata[l] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// RV32I load/store responder: one outstanding request, byte-lane access,
// registered response with extension and error flag, zero sweep after reset.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [7:0]  ERR_COUNT
);
  localparam int BW = ADDR_WIDTH + 2;

  dmem_state_e                 state, nxt;
  logic [ADDR_WIDTH-1:0]       clr_cnt;
  logic                        we_q, err_q;
  logic [2:0]                  f3_q;
  logic [BW-1:0]               addr_q;
  logic [31:0]                 wdata_q;
  logic                        req_err;

  logic                        ram_rd;
  logic [NUM_LANES-1:0]        ram_we;
  logic [ADDR_WIDTH-1:0]       ram_addr;
  logic [NUM_LANES-1:0][7:0]   ram_wdata, ram_rdata;

  assign req_err   = f3_err(REQ_WE, REQ_FUNCT3, REQ_ADDR[1:0]) | (|REQ_ADDR[31:BW]);
  assign REQ_READY = (state == ST_IDLE);
  assign RSP_VALID = (state == ST_RESP);

  // Loads read on the accept edge so the word is ready during ACCESS.
  always_comb begin
    nxt       = state;
    ram_rd    = 1'b0;
    ram_we    = '0;
    ram_addr  = REQ_ADDR[BW-1:2];
    ram_wdata = store_align(f3_q[1:0], wdata_q);
    case (state)
      ST_CLEAR: begin
        ram_addr  = clr_cnt;
        ram_we    = '1;
        ram_wdata = '0;
        if (clr_cnt == '1) nxt = ST_IDLE;
      end
      ST_IDLE: begin
        ram_rd = REQ_VALID;
        if (REQ_VALID) nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        ram_addr = addr_q[BW-1:2];
        if (we_q && !err_q) ram_we = byte_en(f3_q[1:0], addr_q[1:0]);
        nxt = ST_RESP;
      end
      ST_RESP: if (RSP_READY) nxt = ST_IDLE;
      default: nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      state <= nxt;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (state == ST_IDLE && REQ_VALID) begin
        we_q    <= REQ_WE;
        f3_q    <= REQ_FUNCT3;
        addr_q  <= REQ_ADDR[BW-1:0];
        wdata_q <= REQ_WDATA;
        err_q   <= req_err;
      end
      if (state == ST_ACCESS) begin
        RSP_RDATA <= (err_q || we_q) ? 32'h0 : load_ext(f3_q, addr_q[1:0], ram_rdata);
        RSP_ERR   <= err_q;
        if (err_q && ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
      end
    end
  end

  dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .CLK   (CLK),
    .rd_en (ram_rd),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array memory model with an expected-response
// queue, checked every response cycle, plus fixed literal load/store cases.
module tb_dmem_responder;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        CLK, RSTN;
  logic        REQ_VALID, REQ_READY, REQ_WE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic        RSP_VALID, RSP_READY, RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic [7:0]  ERR_COUNT;

  dmem_responder #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .ERR_COUNT(ERR_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  ecnt;
  } exp_t;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] mb [4*DEPTH];
  int         model_ecnt;
  exp_t       exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
    model_ecnt = 0;
  endtask

  // Architectural view: memory is a flat little-endian byte array.
  task automatic model_access(input bit we, input bit [2:0] f3, input bit [31:0] a,
                              input bit [31:0] wd, output exp_t e);
    bit err;
    int i;
    logic [15:0] h;
    err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (we && f3 >= 3'd4) err = 1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) err = 1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) err = 1;
    if (a >= 32'(4*DEPTH)) err = 1;
    e.rdata = 32'h0;
    e.err   = err;
    i = int'(a);
    if (err) begin
      if (model_ecnt < 255) model_ecnt++;
    end else if (we) begin
      case (f3)
        3'd0: mb[i] = wd[7:0];
        3'd1: begin mb[i] = wd[7:0]; mb[i+1] = wd[15:8]; end
        default: for (int k = 0; k < 4; k++) mb[i+k] = wd[8*k +: 8];
      endcase
    end else begin
      h = {mb[i+1], mb[i]};
      case (f3)
        3'd0: e.rdata = {{24{mb[i][7]}}, mb[i]};
        3'd4: e.rdata = {24'h0, mb[i]};
        3'd1: e.rdata = {{16{h[15]}}, h};
        3'd5: e.rdata = {16'h0, h};
        default: e.rdata = {mb[i+3], mb[i+2], mb[i+1], mb[i]};
      endcase
    end
    e.ecnt = 8'(model_ecnt);
  endtask

  // Compare process: every response cycle against the queue head.
  always @(negedge CLK) begin
    if (RSTN && RSP_VALID) begin
      if (exp_q.size() == 0) check("rsp_unexpected", RSP_VALID, 1'b0);
      else begin
        check("rsp_rdata", RSP_RDATA, exp_q[0].rdata);
        check("rsp_err", RSP_ERR, exp_q[0].err);
        check("rsp_ecnt", ERR_COUNT, exp_q[0].ecnt);
      end
    end
  end

  always @(posedge CLK) begin
    if (RSTN && RSP_VALID && RSP_READY && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  task automatic sweep_wait(output int n);
    n = 0;
    do begin
      @(posedge CLK); n++;
      @(negedge CLK);
    end while (!REQ_READY && n < 2000);
  endtask

  task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] wd, input int bp,
                        output logic [31:0] got_rdata, output logic got_err);
    int   n;
    exp_t e;
    got_rdata = 'x; got_err = 'x;
    n = 0;
    @(negedge CLK);
    while (!REQ_READY && n < 50) begin @(negedge CLK); n++; end
    if (!REQ_READY) begin check("ready_timeout", REQ_READY, 1'b1); return; end
    REQ_VALID = 1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = a; REQ_WDATA = wd;
    RSP_READY = (bp == 0);
    @(posedge CLK);
    model_access(we, f3, a, wd, e);
    exp_q.push_back(e);
    #1 REQ_VALID = 0; REQ_ADDR = $urandom; REQ_WDATA = $urandom;
    @(negedge CLK) check("lat_access_vld", RSP_VALID, 1'b0);
    @(negedge CLK) check("lat_resp_vld", RSP_VALID, 1'b1);
    got_rdata = RSP_RDATA; got_err = RSP_ERR;
    for (int k = 0; k < bp; k++) begin
      check("bp_req_ready", REQ_READY, 1'b0);
      check("bp_rsp_valid", RSP_VALID, 1'b1);
      check("bp_hold_rdata", RSP_RDATA, got_rdata);
      REQ_VALID = 1; REQ_WE = $urandom; REQ_FUNCT3 = $urandom; REQ_ADDR = $urandom_range(0, 255);
      @(negedge CLK);
    end
    REQ_VALID = 0; RSP_READY = 1;
    @(posedge CLK);
    @(negedge CLK);
    check("rsp_drop", RSP_VALID, 1'b0);
    check("idle_after", REQ_READY, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        er;
    int          n;
    bit [2:0]    f3;
    bit [31:0]   a;
    bit [2:0]    legal [5];
    legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    RSTN = 0; REQ_VALID = 0; REQ_WE = 0; REQ_FUNCT3 = 0; REQ_ADDR = 0; REQ_WDATA = 0;
    RSP_READY = 1;
    model_reset();
    repeat (3) @(negedge CLK);
    check("rst_req_ready", REQ_READY, 1'b0);
    check("rst_rsp_valid", RSP_VALID, 1'b0);
    check("rst_rsp_rdata", RSP_RDATA, 32'h0);
    check("rst_rsp_err", RSP_ERR, 1'b0);
    check("rst_err_count", ERR_COUNT, 8'h0);
    RSTN = 1;
    sweep_wait(n);
    check("sweep_len", n, DEPTH);

    do_req(0, 3'd2, 32'h000, 0, 0, r, er);
    check("lit_lw_000", r, 32'h0); check("lit_lw_000_err", er, 1'b0);
    do_req(1, 3'd2, 32'h080, 32'hDEADBEEF, 0, r, er);
    do_req(0, 3'd2, 32'h080, 0, 0, r, er); check("lit_lw_080", r, 32'hDEADBEEF);
    do_req(0, 3'd0, 32'h083, 0, 0, r, er); check("lit_lb_083", r, 32'hFFFFFFDE);
    do_req(0, 3'd4, 32'h083, 0, 0, r, er); check("lit_lbu_083", r, 32'h000000DE);
    do_req(0, 3'd1, 32'h082, 0, 0, r, er); check("lit_lh_082", r, 32'hFFFFDEAD);
    do_req(0, 3'd5, 32'h080, 0, 0, r, er); check("lit_lhu_080", r, 32'h0000BEEF);
    do_req(1, 3'd0, 32'h081, 32'h12, 0, r, er);
    do_req(0, 3'd2, 32'h080, 0, 0, r, er); check("lit_sb_merge", r, 32'hDEAD12EF);
    do_req(1, 3'd1, 32'h082, 32'h5678, 0, r, er);
    do_req(0, 3'd2, 32'h080, 0, 0, r, er); check("lit_sh_merge", r, 32'h567812EF);
    do_req(0, 3'd2, 32'h082, 0, 0, r, er);
    check("lit_lw_misal_err", er, 1'b1); check("lit_lw_misal_rdata", r, 32'h0);
    check("lit_ecnt1", ERR_COUNT, 8'd1);
    do_req(1, 3'd1, 32'h085, 32'hFFFF, 0, r, er);
    check("lit_sh_misal_err", er, 1'b1); check("lit_ecnt2", ERR_COUNT, 8'd2);
    do_req(1, 3'd2, 32'h1000, 32'h11111111, 0, r, er);
    check("lit_sw_range_err", er, 1'b1); check("lit_ecnt3", ERR_COUNT, 8'd3);
    do_req(0, 3'd2, 32'h080, 0, 0, r, er); check("lit_unchanged", r, 32'h567812EF);
    do_req(0, 3'd2, 32'h080, 0, 5, r, er); check("lit_bp_rdata", r, 32'h567812EF);

    for (int it = 0; it < 300; it++) begin
      f3 = ($urandom_range(0, 9) != 0) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h1000;
      else begin
        a = $urandom_range(0, 255);
        if ($urandom_range(0, 6) != 0) begin
          if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
          if (f3 == 3'd2) a[1:0] = 2'b00;
        end
      end
      do_req(1'($urandom_range(0, 1)), f3, a, $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, r, er);
    end

    // Reset while a response is pending.
    @(negedge CLK);
    n = 0;
    while (!REQ_READY && n < 50) begin @(negedge CLK); n++; end
    REQ_VALID = 1; REQ_WE = 0; REQ_FUNCT3 = 3'd2; REQ_ADDR = 32'h080; RSP_READY = 0;
    @(posedge CLK);
    begin exp_t e; model_access(0, 3'd2, 32'h080, 0, e); exp_q.push_back(e); end
    #1 REQ_VALID = 0;
    @(negedge CLK); @(negedge CLK);
    check("pre_rst_vld", RSP_VALID, 1'b1);
    #2 RSTN = 0;
    #1;
    check("arst_rsp_valid", RSP_VALID, 1'b0);
    check("arst_req_ready", REQ_READY, 1'b0);
    check("arst_rsp_rdata", RSP_RDATA, 32'h0);
    check("arst_rsp_err", RSP_ERR, 1'b0);
    check("arst_err_count", ERR_COUNT, 8'h0);
    exp_q.delete();
    model_reset();
    @(negedge CLK);
    RSTN = 1; RSP_READY = 1;
    sweep_wait(n);
    check("sweep2_len", n, DEPTH);
    do_req(0, 3'd2, 32'h080, 0, 0, r, er); check("lit_post_sweep", r, 32'h0);

    for (int it = 0; it < 260; it++) do_req(0, 3'd3, 32'($urandom_range(0, 255)), 0, 0, r, er);
    check("lit_ecnt_sat", ERR_COUNT, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
